// File: rtl/mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mac_tx_arbiter
//   Frame-level arbiter that shares the single MAC TX AXI-Stream input among
//   N_PORTS requesters. A port is granted for a whole frame and keeps the grant
//   until its tlast beat is accepted. The next frame is then chosen round-robin.
//   Arbitration costs one idle cycle per frame. While a frame is in flight the
//   datapath is a zero-latency combinational mux.
//   If the granted port drops tvalid while the MAC is ready, a sticky underrun
//   flag is raised for that port. The MAC TX controller needs gap-free frames,
//   so this condition is reported rather than hidden.
//
// Configuration
//   MAC_TX_ARB_PRIO_EN : when defined, port 0 has strict priority at
//                        arbitration time but never preempts a locked frame.
//                        Ports 1..N_PORTS-1 round-robin among themselves.
//                        When undefined, all ports share one round-robin.
//
// Ports
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_clk_en               clock enable; no state advances while low
//   s_tvalid/s_tkeep/s_tdata/s_tlast  per-port slave streams (port p in slice p)
//   s_tready               per-port ready, one-hot or zero
//   m_tvalid/m_tkeep/m_tdata/m_tlast  muxed master stream to the MAC TX
//   m_tready               ready from the MAC TX controller
//   o_grant                one-hot current grant, zero when idle
//   o_busy                 frame in progress
//   o_underrun             sticky per-port underrun flags
//   i_underrun_clr         clears all underrun flags (a new underrun wins)
// ---------------------------------------------------------------------------
module mac_tx_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int N_SYMBOLS = 4,
  parameter int W_SYMBOL  = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_clk_en,
  input  logic [N_PORTS-1:0]                    s_tvalid,
  input  logic [N_PORTS*N_SYMBOLS-1:0]          s_tkeep,
  input  logic [N_PORTS*N_SYMBOLS*W_SYMBOL-1:0] s_tdata,
  input  logic [N_PORTS-1:0]                    s_tlast,
  output logic [N_PORTS-1:0]                    s_tready,
  output logic                                  m_tvalid,
  output logic [N_SYMBOLS-1:0]                  m_tkeep,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]         m_tdata,
  output logic                                  m_tlast,
  input  logic                                  m_tready,
  output logic [N_PORTS-1:0]                    o_grant,
  output logic                                  o_busy,
  output logic [N_PORTS-1:0]                    o_underrun,
  input  logic                                  i_underrun_clr
);

  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int BEAT_W = N_SYMBOLS * W_SYMBOL;

  typedef enum logic {ST_IDLE, ST_PASS} state_t;

  state_t             state_q,    state_d;
  logic [N_PORTS-1:0] grant_q,    grant_d;
  logic [IDX_W-1:0]   gidx_q,     gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [N_PORTS-1:0] underrun_q, underrun_d;

  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic               busy;
  logic               g_valid;
  logic               g_last;
  logic               beat_acc;

  // Winner search: first requester after the last granted port, with wrap.
  // In priority mode, port 0 is taken first and skipped by the rotating search.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef MAC_TX_ARB_PRIO_EN
    if (s_tvalid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % N_PORTS);
`ifdef MAC_TX_ARB_PRIO_EN
      if (!win_found && (cand != '0) && s_tvalid[cand]) begin
`else
      if (!win_found && s_tvalid[cand]) begin
`endif
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Zero-latency datapath mux. The outputs are quiet whenever no frame is locked.
  always_comb begin
    busy     = (state_q == ST_PASS);
    g_valid  = s_tvalid[gidx_q];
    g_last   = s_tlast[gidx_q];
    m_tdata  = '0;
    m_tkeep  = '0;
    if (busy) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (gidx_q == IDX_W'(p)) begin
          m_tdata = s_tdata[p*BEAT_W +: BEAT_W];
          m_tkeep = s_tkeep[p*N_SYMBOLS +: N_SYMBOLS];
        end
      end
    end
    m_tvalid = busy & g_valid;
    m_tlast  = busy & g_last;
    s_tready = '0;
    if (busy && i_clk_en) begin
      s_tready = grant_q & {N_PORTS{m_tready}};
    end
    beat_acc = busy & g_valid & m_tready & i_clk_en;
  end

  // Next-state logic. Every transition is qualified by i_clk_en.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    underrun_d = underrun_q;
    if (i_clk_en) begin
      // Clear first so that a same-cycle underrun re-sets the flag.
      if (i_underrun_clr) begin
        underrun_d = '0;
      end
      if (state_q == ST_IDLE) begin
        if (win_found) begin
          state_d = ST_PASS;
          gidx_d  = win_idx;
          grant_d = {{(N_PORTS-1){1'b0}}, 1'b1} << win_idx;
        end
      end else begin
        // The MAC wants data but the locked source has none: flag it and keep the grant.
        if (m_tready && !g_valid) begin
          underrun_d = underrun_d | grant_q;
        end
        if (beat_acc && g_last) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = gidx_q;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(N_PORTS - 1);
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_busy     = busy;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_arbiter
//   Self-checking bench for mac_tx_arbiter (N_PORTS=4, 4 x 8-bit symbols).
//   Each port has a source queue of frames. The frames are built from random
//   data, keep values and lengths.
//   A frame-level reference model predicts the outputs of the arbiter from
//   the port queues: the owner of the link, the last owner, and the sticky
//   underrun flags.
//   Inputs are driven on the falling edge and sampled 1 ns later.
//   Define MAC_TX_ARB_PRIO_EN to check the priority build.
// ---------------------------------------------------------------------------
module tb_mac_tx_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [3:0]  grant;
    logic        busy;
    logic        mvalid;
    logic [31:0] mdata;
    logic [3:0]  mkeep;
    logic        mlast;
    logic [3:0]  sready;
    logic [3:0]  ur;
  } snap_t;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_clk_en;
  logic [3:0]  s_tvalid;
  logic [15:0] s_tkeep;
  logic [127:0] s_tdata;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic        m_tvalid;
  logic [3:0]  m_tkeep;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic [3:0]  o_underrun;
  logic        i_underrun_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  beat_t      mem [4][1024];
  int         head [4];
  int         tail [4];
  logic [3:0] gap;
  int         owner;
  int         last_owner;
  logic [3:0] exp_ur;
  logic [3:0] prev_grant;
  int         glog [64];
  int         gcnt;

  always #5 clk = ~clk;

  mac_tx_arbiter #(.N_PORTS(4), .N_SYMBOLS(4), .W_SYMBOL(8)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en),
    .s_tvalid(s_tvalid), .s_tkeep(s_tkeep), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tkeep(m_tkeep), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .o_grant(o_grant), .o_busy(o_busy), .o_underrun(o_underrun),
    .i_underrun_clr(i_underrun_clr)
  );

  function automatic int pick(input logic [3:0] req, input int last);
`ifdef MAC_TX_ARB_PRIO_EN
    if (req[0]) return 0;
    for (int i = 1; i <= 4; i++) begin
      if (((last + i) % 4) != 0 && req[(last + i) % 4]) return (last + i) % 4;
    end
`else
    for (int i = 1; i <= 4; i++) begin
      if (req[(last + i) % 4]) return (last + i) % 4;
    end
`endif
    return -1;
  endfunction

  function automatic bit all_idle();
    if (owner >= 0) return 1'b0;
    for (int p = 0; p < 4; p++) if (head[p] != tail[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic reset_model();
    owner = -1; last_owner = 3; exp_ur = '0; gap = '0; prev_grant = '0; gcnt = 0;
    for (int p = 0; p < 4; p++) begin head[p] = 0; tail[p] = 0; end
  endtask

  task automatic add_frame(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.keep = (i == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
      b.last = (i == len - 1);
      mem[p][tail[p]] = b;
      tail[p]++;
    end
  endtask

  // One clock: drive the sources, sample the DUT, predict the outputs, advance the model.
  task automatic step(input logic ce, input logic rdy, input logic clr,
                      output snap_t obs, output snap_t exp);
    logic [3:0] vld;
    beat_t fb;
    int o;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      vld[p] = (head[p] != tail[p]) && !gap[p];
      if (head[p] != tail[p]) fb = mem[p][head[p]];
      else begin fb.data = $urandom; fb.keep = 4'($urandom); fb.last = 1'($urandom); end
      s_tdata[p*32 +: 32] = fb.data;
      s_tkeep[p*4 +: 4]   = fb.keep;
      s_tlast[p]          = fb.last;
    end
    s_tvalid = vld; i_clk_en = ce; m_tready = rdy; i_underrun_clr = clr;
    #1;
    o = owner;
    exp = '0;
    exp.ur = exp_ur;
    if (o >= 0) begin
      exp.grant  = 4'b0001 << o;
      exp.busy   = 1'b1;
      exp.mvalid = vld[o];
      if (ce && rdy) exp.sready = 4'b0001 << o;
      if (vld[o]) begin
        fb = mem[o][head[o]];
        exp.mdata = fb.data; exp.mkeep = fb.keep; exp.mlast = fb.last;
      end
    end
    obs = '0;
    obs.grant = o_grant; obs.busy = o_busy; obs.mvalid = m_tvalid;
    obs.sready = s_tready; obs.ur = o_underrun;
    if (exp.mvalid) begin obs.mdata = m_tdata; obs.mkeep = m_tkeep; obs.mlast = m_tlast; end
    if (o_grant != 4'b0 && prev_grant == 4'b0) begin
      for (int p = 0; p < 4; p++) if (o_grant[p]) glog[gcnt] = p;
      if (gcnt < 63) gcnt++;
    end
    prev_grant = o_grant;
    if (ce && clr) exp_ur = '0;
    if (o >= 0) begin
      if (ce && rdy && !vld[o]) exp_ur[o] = 1'b1;
      if (ce && rdy && vld[o]) begin
        fb = mem[o][head[o]];
        head[o]++;
        if (fb.last) begin last_owner = o; owner = -1; end
      end
    end else if (ce) begin
      owner = pick(vld, last_owner);
    end
  endtask

  task automatic test_reset();
    snap_t obs, exp;
    i_reset_n = 1'b0; i_clk_en = 1'b1; m_tready = 1'b1; i_underrun_clr = 1'b0;
    s_tvalid = 4'hF; s_tkeep = '0; s_tdata = '0; s_tlast = '0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (o_grant !== 4'b0) begin n_fail++; $display("FAIL rst_grant got=%b want=0000", o_grant); end
    n_cmp++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0) begin n_fail++;
      $display("FAIL rst_stream got m_tvalid=%b s_tready=%b want 0/0000", m_tvalid, s_tready); end
    n_cmp++; if (o_busy !== 1'b0 || o_underrun !== 4'b0) begin n_fail++;
      $display("FAIL rst_flags got busy=%b ur=%b want 0/0000", o_busy, o_underrun); end
    s_tvalid = '0; i_clk_en = 1'b0;
    @(negedge clk); i_reset_n = 1'b1;
    // start a frame on port 2 and leave an underrun flag behind
    add_frame(2, 6);
    for (int c = 0; c < 4; c++) begin
      gap[2] = (c == 2);
      step(1'b1, 1'b1, 1'b0, obs, exp);
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t1_cyc%0d got=%h want=%h", c, obs, exp); end
    end
    gap = '0;
    step(1'b1, 1'b1, 1'b0, obs, exp);
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t1_pre got=%h want=%h", obs, exp); end
    n_cmp++; if (o_underrun !== 4'b0100) begin n_fail++; $display("FAIL t1_ur_set got=%b want=0100", o_underrun); end
    // asynchronous reset in the middle of the cycle
    #3 i_reset_n = 1'b0;
    #1;
    n_cmp++; if (o_grant !== 4'b0) begin n_fail++; $display("FAIL t1_midrst_grant got=%b want=0000", o_grant); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL t1_midrst_mvalid got=%b want=0", m_tvalid); end
    n_cmp++; if (o_underrun !== 4'b0) begin n_fail++; $display("FAIL t1_midrst_ur got=%b want=0000", o_underrun); end
    n_cmp++; if (s_tready !== 4'b0 || o_busy !== 1'b0) begin n_fail++;
      $display("FAIL t1_midrst_rdy got s_tready=%b busy=%b want 0000/0", s_tready, o_busy); end
    s_tvalid = '0; i_clk_en = 1'b0;
    @(posedge clk);
    @(negedge clk); i_reset_n = 1'b1;
    reset_model();
  endtask

  task automatic test_rr_fairness();
    snap_t obs, exp;
    int cyc;
`ifdef MAC_TX_ARB_PRIO_EN
    int ord [8] = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    int ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    gcnt = 0; cyc = 0;
    for (int f = 0; f < 2; f++) for (int p = 0; p < 4; p++) add_frame(p, 3);
    while (!all_idle() && cyc < 200) begin
      step(1'b1, 1'b1, 1'b0, obs, exp);
      cyc++;
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t2_cyc%0d got=%h want=%h", cyc, obs, exp); end
    end
    n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL t2_cycles got=%0d want=32", cyc); end
    n_cmp++; if (gcnt !== 8) begin n_fail++; $display("FAIL t2_grants got=%0d want=8", gcnt); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (glog[i] !== ord[i]) begin n_fail++; $display("FAIL t2_order%0d got=%0d want=%0d", i, glog[i], ord[i]); end
    end
  endtask

  task automatic test_lock();
    snap_t obs, exp;
    int cyc;
    gcnt = 0; cyc = 0;
    add_frame(1, 4);
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 1'b0, obs, exp);
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t3_pre%0d got=%h want=%h", c, obs, exp); end
    end
    add_frame(0, 2);
    step(1'b1, 1'b1, 1'b0, obs, exp);
    n_cmp++; if (obs.sready !== 4'b0010 || obs.grant !== 4'b0010) begin n_fail++;
      $display("FAIL t3_locked got rdy=%b grant=%b want 0010/0010", obs.sready, obs.grant); end
    while (!all_idle() && cyc < 100) begin
      step(1'b1, 1'b1, 1'b0, obs, exp);
      cyc++;
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t3_cyc%0d got=%h want=%h", cyc, obs, exp); end
    end
    n_cmp++; if (gcnt !== 2 || glog[0] !== 1 || glog[1] !== 0) begin n_fail++;
      $display("FAIL t3_order got n=%0d %0d,%0d want 2 1,0", gcnt, glog[0], glog[1]); end
  endtask

  task automatic test_backpressure();
    snap_t obs, exp;
    int cyc, ce_left, total, acc;
    logic ce, rdy;
    cyc = 0; ce_left = 0; total = 0; acc = 0;
    for (int p = 0; p < 4; p++) begin
      for (int f = 0; f < 4; f++) begin
        int len;
        len = $urandom_range(1, 6);
        add_frame(p, len);
        total += len;
      end
    end
    while (!all_idle() && cyc < 3000) begin
      if (ce_left > 0) begin ce = 1'b0; ce_left--; end
      else if ($urandom_range(0, 5) == 0) begin ce = 1'b0; ce_left = $urandom_range(0, 2); end
      else ce = 1'b1;
      rdy = (cyc < 200) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      step(ce, rdy, 1'b0, obs, exp);
      cyc++;
      if (obs.mvalid && rdy && ce) acc++;
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t4_cyc%0d got=%h want=%h", cyc, obs, exp); end
    end
    n_cmp++; if (!all_idle()) begin n_fail++; $display("FAIL t4_timeout got cycles=%0d want drained", cyc); end
    n_cmp++; if (acc !== total) begin n_fail++; $display("FAIL t4_beats got=%0d want=%0d", acc, total); end
  endtask

  task automatic test_underrun();
    snap_t obs, exp;
    int cyc;
    cyc = 0;
    add_frame(3, 5);
    for (int c = 0; c < 3; c++) begin
      gap[3] = (c == 2);
      step(1'b1, 1'b1, 1'b0, obs, exp);
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t5_pre%0d got=%h want=%h", c, obs, exp); end
    end
    gap = '0;
    while (!all_idle() && cyc < 100) begin
      step(1'b1, 1'b1, 1'b0, obs, exp);
      cyc++;
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t5_cyc%0d got=%h want=%h", cyc, obs, exp); end
    end
    step(1'b1, 1'b1, 1'b0, obs, exp);
    n_cmp++; if (obs.ur !== 4'b1000) begin n_fail++; $display("FAIL t5_sticky got=%b want=1000", obs.ur); end
    step(1'b1, 1'b1, 1'b1, obs, exp);
    step(1'b1, 1'b1, 1'b0, obs, exp);
    n_cmp++; if (obs.ur !== 4'b0000) begin n_fail++; $display("FAIL t5_clear got=%b want=0000", obs.ur); end
    // a new underrun in the same cycle as a clear request keeps the flag set
    add_frame(3, 3);
    step(1'b1, 1'b1, 1'b0, obs, exp);
    step(1'b1, 1'b1, 1'b0, obs, exp);
    gap[3] = 1'b1;
    step(1'b1, 1'b1, 1'b1, obs, exp);
    gap = '0;
    step(1'b1, 1'b1, 1'b0, obs, exp);
    n_cmp++; if (obs.ur !== 4'b1000) begin n_fail++; $display("FAIL t5_setwins got=%b want=1000", obs.ur); end
    cyc = 0;
    while (!all_idle() && cyc < 100) begin
      step(1'b1, 1'b1, 1'b0, obs, exp);
      cyc++;
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t5_tail%0d got=%h want=%h", cyc, obs, exp); end
    end
  endtask

  task automatic test_priority();
    snap_t obs, exp;
    int cyc;
`ifdef MAC_TX_ARB_PRIO_EN
    int ord [3] = '{0, 0, 0};
`else
    int ord [3] = '{2, 0, 2};
`endif
    cyc = 0;
    add_frame(0, 1);
    while (!all_idle() && cyc < 20) begin step(1'b1, 1'b1, 1'b0, obs, exp); cyc++; end
    gcnt = 0; cyc = 0;
    for (int f = 0; f < 3; f++) begin add_frame(0, 2); add_frame(2, 2); end
    while (!all_idle() && cyc < 100) begin
      step(1'b1, 1'b1, 1'b0, obs, exp);
      cyc++;
      n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL t6_cyc%0d got=%h want=%h", cyc, obs, exp); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (glog[i] !== ord[i]) begin n_fail++; $display("FAIL t6_order%0d got=%0d want=%0d", i, glog[i], ord[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_lock();
    test_backpressure();
    test_underrun();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
